// File: rtl/plot_sink_pkg.sv
// plot_sink_pkg: screen geometry, framebuffer address width, FSM state
// encoding and the plot request record. This package is shared by the glyph
// drawers, plot_sink and the VGA adapter wrapper.
package plot_sink_pkg;

  localparam int unsigned SCREEN_W   = 160;
  localparam int unsigned SCREEN_H   = 120;
  localparam int unsigned COLOUR_W   = 3;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned PIXELS     = SCREEN_W * SCREEN_H;

  localparam logic [7:0]        X_LIMIT   = 8'(SCREEN_W);
  localparam logic [6:0]        Y_LIMIT   = 7'(SCREEN_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1
  } state_t;

  typedef struct packed {
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
  } plot_t;

  // y*160 + x as y*128 + y*32 + x, widened to ADDR_W before the shifts so
  // no high bits of y are lost.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x,
                                                 input logic [6:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 7) + (yw << 5) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/plot_sink_fifo.sv
// plot_fifo: synchronous FIFO that buffers plot requests.
// Ports: clk, rst (async, active high), push/din, pop/dout (dout shows the
// head entry), full, empty. A push while full or a pop while empty is ignored.
module plot_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/plot_sink.sv
// plot_sink: receiving end of the glyph-drawer pixel stream. It accepts
// (x,y,colour) plot requests over valid/ready, buffers them and writes them
// into the 160x120 framebuffer. It also runs a full-screen clear on request.
// Ports: clk, reset (async, active high); in_valid/in_ready/in_x/in_y/in_colour
// form the plot request stream; clear_req/clear_colour start a clear;
// mem_we/mem_ready/mem_addr/mem_data drive the framebuffer write port;
// clear_done pulses once after a clear; busy and oob_count report status.
module plot_sink
  import plot_sink_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_x,
  input  logic [6:0]          in_y,
  input  logic [COLOUR_W-1:0] in_colour,
  input  logic                clear_req,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                clear_done,
  output logic                busy,
  output logic [7:0]          oob_count
);

  state_t              state;
  logic                clear_pending;
  logic [COLOUR_W-1:0] clear_colour_q;

  plot_t head;
  plot_t req;
  logic  fifo_full;
  logic  fifo_empty;
  logic  accept;
  logic  in_range;
  logic  slot_free;
  logic  pop;
  logic  go_clear;

  assign req       = '{x: in_x, y: in_y, colour: in_colour};
  assign in_ready  = !reset && !fifo_full && !clear_pending && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign in_range  = (in_x < X_LIMIT) && (in_y < Y_LIMIT);
  // The output register can take a new write if it is empty or if its
  // current write completes on this edge.
  assign slot_free = !mem_we || mem_ready;
  assign pop       = (state == IDLE) && !fifo_empty && slot_free;
  assign go_clear  = (state == IDLE) && clear_pending && fifo_empty && slot_free;
  assign busy      = (state != IDLE) || !fifo_empty || clear_pending;

  plot_fifo #(
    .WIDTH ($bits(plot_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (accept && in_range),
    .din   (req),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      clear_pending  <= 1'b0;
      clear_colour_q <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_data       <= '0;
      clear_done     <= 1'b0;
      oob_count      <= '0;
    end else begin
      clear_done <= 1'b0;

      if (accept && !in_range && (oob_count != 8'hFF))
        oob_count <= oob_count + 8'd1;

      if (clear_req && (state != CLEAR)) begin
        clear_pending  <= 1'b1;
        clear_colour_q <= clear_colour;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            mem_we   <= 1'b1;
            mem_addr <= pix_addr(head.x, head.y);
            mem_data <= head.colour;
          end else if (go_clear) begin
            state    <= CLEAR;
            mem_we   <= 1'b1;
            mem_addr <= '0;
            mem_data <= clear_colour_q;
          end else if (mem_ready) begin
            mem_we <= 1'b0;
          end
        end
        CLEAR: begin
          // mem_addr doubles as the sweep counter; it advances only on a
          // completed write.
          if (mem_ready) begin
            if (mem_addr == LAST_ADDR) begin
              mem_we        <= 1'b0;
              clear_done    <= 1'b1;
              clear_pending <= 1'b0;
              state         <= IDLE;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_sink.sv
// tb_plot_sink: directed bench for plot_sink. Inputs change and outputs are
// sampled 1 ns after each rising clock edge.
module tb_plot_sink;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic       mem_we;
  logic       mem_ready;
  logic [14:0] mem_addr;
  logic [2:0] mem_data;
  logic       clear_done;
  logic       busy;
  logic [7:0] oob_count;

  int vectors = 0;
  int miscompares = 0;

  plot_sink dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_colour    (in_colour),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .mem_we       (mem_we),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .clear_done   (clear_done),
    .busy         (busy),
    .oob_count    (oob_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_plot(input int x, input int y, input int c);
    in_valid  = 1'b1;
    in_x      = 8'(x);
    in_y      = 7'(y);
    in_colour = 3'(c);
  endtask

  function automatic int bp_x(input int i); return i * 20 + 1; endfunction
  function automatic int bp_y(input int i); return i * 7 + 2;  endfunction

  initial begin
    int idx;
    int first_bad;
    int ready_seen;
    int done_cnt;
    int exp_a;
    int exp_d;
    int extra_we;
    int extra_done;
    logic acc;

    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
    clear_req = 1'b0; clear_colour = '0; mem_ready = 1'b1;

    // Reset state
    step(); step();
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_oob", oob_count, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    step();
    check("post_rst_no_we", mem_we, 0);

    // Single plot x=10 y=5 c=3: write visible two edges after the accept
    drive_plot(10, 5, 3);
    check("single_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("single_we_early", mem_we, 0);
    step();
    check("single_we", mem_we, 1);
    check("single_addr", mem_addr, 810);
    check("single_data", mem_data, 3);
    step();
    check("single_we_done", mem_we, 0);

    // Backpressure: 5 accepted (4 queued + 1 held in the output register)
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_plot(bp_x(i), bp_y(i), i);
      check($sformatf("bp_ready_%0d", i), in_ready, 1);
      step();
    end
    drive_plot(bp_x(5), bp_y(5), 5);
    check("bp_full_ready", in_ready, 0);
    check("bp_hold_we", mem_we, 1);
    check("bp_hold_addr", mem_addr, 32'(bp_y(0) * 160 + bp_x(0)));
    step(); step();
    check("bp_stall_we", mem_we, 1);
    check("bp_stall_addr", mem_addr, 32'(bp_y(0) * 160 + bp_x(0)));
    check("bp_stall_data", mem_data, 0);
    mem_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) in_valid = 1'b0;
      check($sformatf("bp_we_%0d", i), mem_we, 1);
      check($sformatf("bp_addr_%0d", i), mem_addr, 32'(bp_y(i) * 160 + bp_x(i)));
      check($sformatf("bp_data_%0d", i), mem_data, 32'(i));
    end
    check("bp_valid_taken", in_valid, 0);
    step();
    check("bp_idle_we", mem_we, 0);
    check("bp_idle_busy", busy, 0);

    // Out-of-range requests are consumed but never written
    drive_plot(160, 0, 1);
    check("oob_x_ready", in_ready, 1);
    step();
    drive_plot(0, 120, 2);
    check("oob_y_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("oob_no_we_a", mem_we, 0);
    step();
    check("oob_no_we_b", mem_we, 0);
    check("oob_count_2", oob_count, 2);
    drive_plot(200, 0, 4);
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    check("oob_no_we_c", mem_we, 0);
    check("oob_sat", oob_count, 255);
    step();

    // Clear with two queued plots, colour 5
    mem_ready = 1'b0;
    drive_plot(1, 0, 2);
    step();
    drive_plot(159, 119, 7);
    step();
    in_valid = 1'b0;
    clear_req = 1'b1; clear_colour = 3'd5;
    step();
    clear_req = 1'b0; clear_colour = 3'd0;
    check("clr_pending_ready", in_ready, 0);
    check("clr_pending_busy", busy, 1);
    drive_plot(3, 3, 1);
    mem_ready = 1'b1;
    idx = 0; first_bad = -1; ready_seen = 0; done_cnt = 0;
    for (int cyc = 0; cyc < 19500; cyc++) begin
      if (clear_done) begin
        done_cnt++;
        in_valid = 1'b0;
        break;
      end
      if (in_ready) ready_seen++;
      if (mem_we) begin
        if (idx == 0)      begin exp_a = 1;     exp_d = 2; end
        else if (idx == 1) begin exp_a = 19199; exp_d = 7; end
        else               begin exp_a = idx - 2; exp_d = 5; end
        if (first_bad < 0 && (int'(mem_addr) != exp_a || int'(mem_data) != exp_d))
          first_bad = idx;
        idx++;
      end
      clear_req = (idx == 100);
      step();
    end
    clear_req = 1'b0;
    check("clr_done_seen", done_cnt, 1);
    check("clr_write_count", idx, 19202);
    check("clr_first_bad_idx", first_bad, -1);
    check("clr_ready_low", ready_seen, 0);
    check("clr_done_we", mem_we, 0);
    extra_we = 0; extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_we) extra_we++;
      if (clear_done) extra_done++;
    end
    check("clr_no_second_clear", extra_we, 0);
    check("clr_single_done", extra_done, 0);
    check("clr_idle_busy", busy, 0);

    // Reset mid-stream with 3 requests queued
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_plot(bp_x(i), bp_y(i), i + 1);
      step();
    end
    in_valid = 1'b0;
    check("mid_busy_before", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_data", mem_data, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_oob", oob_count, 0);
    check("mid_rst_done", clear_done, 0);
    step();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("mid_rel_ready", in_ready, 1);
    extra_we = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_we) extra_we++;
    end
    check("mid_rel_no_we", extra_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
